unidad_desplazamiento: RTL and testbench

UNIDAD_DESPLAZAMIENTO -- requirements
Module: unidad_desplazamiento

---
 rtl/unidad_desplazamiento_pkg.sv | 34 +++
 rtl/desplazamiento_derecha.sv | 28 ++
 rtl/unidad_desplazamiento.sv | 220 ++++++++++++++++++++++
 tb/tb_unidad_desplazamiento.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/unidad_desplazamiento_pkg.sv
// -----------------------------------------------------------------------------
// unidad_desplazamiento_pkg
// Shared ALU definitions for the shift unit:
//   - estado_t : FSM state encoding (REPOSO, CALCULO, ENTREGA)
//   - MODO_*   : operation codes carried on the modo input
//   - ANCHO / CANT_W : operand and shift-amount widths
//   - mascara_alta() : mask with the top 'cant' bits set, used for sign fill
// No ports (package).
// -----------------------------------------------------------------------------
package unidad_desplazamiento_pkg;

  localparam int ANCHO  = 8;
  localparam int CANT_W = 3;

  typedef enum logic [1:0] {
    REPOSO  = 2'b00,
    CALCULO = 2'b01,
    ENTREGA = 2'b10
  } estado_t;

  localparam logic [1:0] MODO_LOGICO = 2'b00;
  localparam logic [1:0] MODO_ARIT   = 2'b01;
  localparam logic [1:0] MODO_ROTA   = 2'b10;
  localparam logic [1:0] MODO_RES    = 2'b11;

  // Top 'cant' bits set, the rest clear. cant = 0 gives an all-zero mask,
  // so sign fill naturally disappears for a zero shift.
  function automatic logic [ANCHO-1:0] mascara_alta(input logic [CANT_W-1:0] cant);
    logic [ANCHO-1:0] todos;
    todos = '1;
    return ~(todos >> cant);
  endfunction

endpackage

// File: rtl/desplazamiento_derecha.sv
// -----------------------------------------------------------------------------
// desplazamiento_derecha
// Combinational logical right shifter (zero fill), built as a three-stage
// logarithmic barrel: each stage shifts by 1, 2 or 4 depending on one bit of
// the shift amount.
// Ports:
//   valor     in  [7:0]  operand
//   cant      in  [2:0]  shift amount 0..7
//   resultado out [7:0]  valor >> cant, zero filled
// -----------------------------------------------------------------------------
module desplazamiento_derecha
  import unidad_desplazamiento_pkg::*;
(
  input  logic [ANCHO-1:0]  valor,
  input  logic [CANT_W-1:0] cant,
  output logic [ANCHO-1:0]  resultado
);

  logic [ANCHO-1:0] etapa_1;
  logic [ANCHO-1:0] etapa_2;

  always_comb begin
    etapa_1   = cant[0] ? {1'b0, valor[ANCHO-1:1]}   : valor;
    etapa_2   = cant[1] ? {2'b0, etapa_1[ANCHO-1:2]} : etapa_1;
    resultado = cant[2] ? {4'b0, etapa_2[ANCHO-1:4]} : etapa_2;
  end

endmodule

// File: rtl/unidad_desplazamiento.sv
// -----------------------------------------------------------------------------
// unidad_desplazamiento
// Multi-cycle right-shift unit: logical, arithmetic and rotate right of an
// 8-bit operand by 0..7, with zero / carry / bad-mode flags and a counter of
// delivered results.
//
// Ports:
//   clk             in   rising-edge clock
//   rst_n           in   synchronous active-low reset
//   entrada_valida  in   request present
//   entrada_lista   out  unit can accept a request (registered)
//   valor_in        in   [7:0] operand
//   cant_mov        in   [2:0] shift amount
//   modo            in   [1:0] 00 logical, 01 arithmetic, 10 rotate, 11 reserved
//   salida_valida   out  result present
//   salida_lista    in   consumer accepts the result
//   resultado       out  [7:0] shifted value
//   bandera_cero    out  resultado == 0
//   bandera_acarreo out  last bit shifted out
//   error_modo      out  request used the reserved mode
//   contador_ops    out  [7:0] completed output handshakes, wraps
//   estado          out  current FSM state, for observation only
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. A producer holding valid keeps its data stable until that edge;
// ready never depends combinationally on valid in this block.
//
// Timeline: request accepted at edge N (REPOSO -> CALCULO), results
// registered at edge N+1 (CALCULO -> ENTREGA), so salida_valida is first
// sampled high at edge N+2.
// -----------------------------------------------------------------------------
module unidad_desplazamiento
  import unidad_desplazamiento_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              entrada_valida,
  output logic              entrada_lista,
  input  logic [ANCHO-1:0]  valor_in,
  input  logic [CANT_W-1:0] cant_mov,
  input  logic [1:0]        modo,
  output logic              salida_valida,
  input  logic              salida_lista,
  output logic [ANCHO-1:0]  resultado,
  output logic              bandera_cero,
  output logic              bandera_acarreo,
  output logic              error_modo,
  output logic [7:0]        contador_ops,
  output estado_t           estado
);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  estado_t estado_q;
  estado_t estado_sig;
  logic    aceptar;
  logic    entregar;
  logic    lista_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado_q <= REPOSO;
    end else begin
      estado_q <= estado_sig;
    end
  end

  always_comb begin
    estado_sig = estado_q;
    aceptar    = 1'b0;
    entregar   = 1'b0;
    case (estado_q)
      REPOSO: begin
        if (entrada_valida && lista_q) begin
          aceptar    = 1'b1;
          estado_sig = CALCULO;
        end
      end
      CALCULO: begin
        estado_sig = ENTREGA;
      end
      ENTREGA: begin
        if (salida_lista) begin
          entregar   = 1'b1;
          estado_sig = REPOSO;
        end
      end
      default: begin
        estado_sig = REPOSO;
      end
    endcase
  end

  // Ready is a flop of "next state is REPOSO". It equals (estado_q == REPOSO)
  // in normal operation but is held low during reset and only rises on the
  // first edge after rst_n is released. Because it is registered, the cycle
  // in which an output handshake completes always shows ready = 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lista_q <= 1'b0;
    end else begin
      lista_q <= (estado_sig == REPOSO);
    end
  end

  assign entrada_lista = lista_q;
  assign salida_valida = (estado_q == ENTREGA);
  assign estado        = estado_q;

  // ---------------------------------------------------------------------------
  // Operand latches: only written on acceptance, so inputs that change while
  // the unit is busy never reach the datapath.
  // ---------------------------------------------------------------------------
  logic [ANCHO-1:0]  op_valor;
  logic [CANT_W-1:0] op_cant;
  logic [1:0]        op_modo;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_valor <= '0;
      op_cant  <= '0;
      op_modo  <= MODO_LOGICO;
    end else if (aceptar) begin
      op_valor <= valor_in;
      op_cant  <= cant_mov;
      op_modo  <= modo;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: one shared logical shifter; arithmetic and rotate are formed by
  // ORing extra bits into the vacated top positions.
  // ---------------------------------------------------------------------------
  logic [ANCHO-1:0] logico;
  logic [ANCHO-1:0] relleno_signo;
  logic [ANCHO-1:0] relleno_rota;
  logic [3:0]       cant_rota;
  logic             bit_saliente;
  logic [ANCHO-1:0] calc_resultado;
  logic             calc_acarreo;
  logic             calc_error;

  desplazamiento_derecha u_desplazamiento (
    .valor     (op_valor),
    .cant      (op_cant),
    .resultado (logico)
  );

  always_comb begin
    relleno_signo  = '0;
    relleno_rota   = '0;
    cant_rota      = 4'd8 - {1'b0, op_cant};
    bit_saliente   = 1'b0;
    calc_resultado = op_valor;
    calc_acarreo   = 1'b0;
    calc_error     = 1'b0;

    if (op_valor[ANCHO-1]) begin
      relleno_signo = mascara_alta(op_cant);
    end

    // For cant = 0 the left shift is by 8, which clears an 8-bit value, so
    // rotate by zero degenerates to the plain operand.
    relleno_rota = op_valor << cant_rota;

    // The last bit shifted out is valor[cant-1]; nothing leaves for cant = 0.
    if (op_cant != '0) begin
      bit_saliente = op_valor[op_cant - 3'd1];
    end

    case (op_modo)
      MODO_LOGICO: begin
        calc_resultado = logico;
        calc_acarreo   = bit_saliente;
      end
      MODO_ARIT: begin
        calc_resultado = logico | relleno_signo;
        calc_acarreo   = bit_saliente;
      end
      MODO_ROTA: begin
        calc_resultado = logico | relleno_rota;
        calc_acarreo   = bit_saliente;
      end
      default: begin
        // Reserved mode: pass the operand through and flag it.
        calc_resultado = op_valor;
        calc_acarreo   = 1'b0;
        calc_error     = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Result registers: loaded only in CALCULO, then held through ENTREGA.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resultado       <= '0;
      bandera_cero    <= 1'b0;
      bandera_acarreo <= 1'b0;
      error_modo      <= 1'b0;
    end else if (estado_q == CALCULO) begin
      resultado       <= calc_resultado;
      bandera_cero    <= (calc_resultado == '0);
      bandera_acarreo <= calc_acarreo;
      error_modo      <= calc_error;
    end
  end

  // Delivered-result counter; wraps naturally at 8 bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      contador_ops <= 8'd0;
    end else if (entregar) begin
      contador_ops <= contador_ops + 8'd1;
    end
  end

endmodule

// File: tb/tb_unidad_desplazamiento.sv
// -----------------------------------------------------------------------------
// tb_unidad_desplazamiento
// Self-checking bench for unidad_desplazamiento: a table of fixed vectors,
// random vectors checked against a bit-serial reference model, and
// hand-written sequences for stall, reset mid-operation and counter wrap.
// -----------------------------------------------------------------------------
module tb_unidad_desplazamiento;
  import unidad_desplazamiento_pkg::*;

  localparam int W = 11;  // {resultado[7:0], cero, acarreo, error}

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       entrada_valida = 1'b0;
  logic       entrada_lista;
  logic [7:0] valor_in = 8'd0;
  logic [2:0] cant_mov = 3'd0;
  logic [1:0] modo = 2'd0;
  logic       salida_valida;
  logic       salida_lista = 1'b0;
  logic [7:0] resultado;
  logic       bandera_cero;
  logic       bandera_acarreo;
  logic       error_modo;
  logic [7:0] contador_ops;
  estado_t    estado;

  always #5 clk = ~clk;

  unidad_desplazamiento dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .entrada_valida  (entrada_valida),
    .entrada_lista   (entrada_lista),
    .valor_in        (valor_in),
    .cant_mov        (cant_mov),
    .modo            (modo),
    .salida_valida   (salida_valida),
    .salida_lista    (salida_lista),
    .resultado       (resultado),
    .bandera_cero    (bandera_cero),
    .bandera_acarreo (bandera_acarreo),
    .error_modo      (error_modo),
    .contador_ops    (contador_ops),
    .estado          (estado)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int          pass_cnt = 0;
  int          total_cnt = 0;
  logic [W-1:0] exp_q[$];
  logic [7:0]  exp_cnt = 8'd0;

  task automatic check(input string nombre, input logic [31:0] actual, input logic [31:0] esperado);
    total_cnt++;
    if (actual === esperado) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nombre, actual, esperado, $time);
  endtask

  // Reference model: shifts one bit at a time, tracking the bit that leaves.
  function automatic logic [W-1:0] modelo(input logic [7:0] v, input logic [2:0] c, input logic [1:0] m);
    logic [7:0] r;
    logic       k;
    logic       err;
    r   = v;
    k   = 1'b0;
    err = 1'b0;
    if (m == 2'b11) begin
      err = 1'b1;
    end else begin
      for (int i = 0; i < int'(c); i++) begin
        k = r[0];
        case (m)
          2'b00:   r = {1'b0, r[7:1]};
          2'b01:   r = {r[7], r[7:1]};
          default: r = {r[0], r[7:1]};
        endcase
      end
    end
    return {r, (r == 8'd0), k, err};
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks (all entered and left at #1 after a rising edge)
  // ---------------------------------------------------------------------------
  task automatic enviar(input logic [7:0] v, input logic [2:0] c, input logic [1:0] m,
                        input logic [W-1:0] esp, input bit ver_latencia);
    int espera;
    espera = 0;
    while (entrada_lista !== 1'b1 && espera < 20) begin
      @(posedge clk); #1;
      espera++;
    end
    check("espera_entrada_lista", 32'(entrada_lista), 1);
    valor_in       = v;
    cant_mov       = c;
    modo           = m;
    entrada_valida = 1'b1;
    exp_q.push_back(esp);
    @(posedge clk); #1;  // acceptance edge N
    entrada_valida = 1'b0;
    valor_in       = 8'($urandom_range(0, 255));
    cant_mov       = 3'($urandom_range(0, 7));
    modo           = 2'($urandom_range(0, 3));
    if (ver_latencia) begin
      check("latencia_borde_n1", 32'(salida_valida), 0);
      check("lista_tras_aceptar", 32'(entrada_lista), 0);
      @(posedge clk); #1;
      check("latencia_borde_n2", 32'(salida_valida), 1);
    end
  endtask

  task automatic recoger(input int retener);
    int           espera;
    logic [W-1:0] esp;
    logic [7:0]   res_visto;
    espera = 0;
    while (salida_valida !== 1'b1 && espera < 20) begin
      @(posedge clk); #1;
      espera++;
    end
    check("espera_salida_valida", 32'(salida_valida), 1);
    if (exp_q.size() == 0) begin
      total_cnt++;
      $display("FAIL scoreboard: output seen with empty expected queue (t=%0t)", $time);
      return;
    end
    esp       = exp_q.pop_front();
    res_visto = resultado;
    for (int i = 0; i < retener; i++) begin
      valor_in       = 8'($urandom_range(0, 255));
      cant_mov       = 3'($urandom_range(0, 7));
      modo           = 2'($urandom_range(0, 3));
      entrada_valida = 1'b1;
      @(posedge clk); #1;
      check("estable_resultado", 32'(resultado), 32'(res_visto));
      check("estable_salida_valida", 32'(salida_valida), 1);
      check("retenido_entrada_lista", 32'(entrada_lista), 0);
    end
    entrada_valida = 1'b0;
    check("resultado", 32'(resultado), 32'(esp[10:3]));
    check("bandera_cero", 32'(bandera_cero), 32'(esp[2]));
    check("bandera_acarreo", 32'(bandera_acarreo), 32'(esp[1]));
    check("error_modo", 32'(error_modo), 32'(esp[0]));
    salida_lista = 1'b1;
    @(posedge clk); #1;  // output handshake edge
    salida_lista = 1'b0;
    exp_cnt++;
    check("contador_ops", 32'(contador_ops), 32'(exp_cnt));
    check("valida_baja_tras_entrega", 32'(salida_valida), 0);
    check("lista_tras_entrega", 32'(entrada_lista), 1);
  endtask

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [7:0] valor;
    logic [2:0] cant;
    logic [1:0] modo;
    logic [7:0] res;
    logic       cero;
    logic       acarreo;
    logic       error;
  } vector_t;

  vector_t tabla[12];

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [7:0] v;
    logic [2:0] c;
    logic [1:0] m;
    int         espera;

    tabla[0]  = '{8'hB4, 3'd3, 2'b00, 8'h16, 1'b0, 1'b1, 1'b0};
    tabla[1]  = '{8'h80, 3'd7, 2'b01, 8'hFF, 1'b0, 1'b0, 1'b0};
    tabla[2]  = '{8'h81, 3'd1, 2'b10, 8'hC0, 1'b0, 1'b1, 1'b0};
    tabla[3]  = '{8'h01, 3'd1, 2'b00, 8'h00, 1'b1, 1'b1, 1'b0};
    tabla[4]  = '{8'h5A, 3'd0, 2'b00, 8'h5A, 1'b0, 1'b0, 1'b0};
    tabla[5]  = '{8'h5A, 3'd0, 2'b01, 8'h5A, 1'b0, 1'b0, 1'b0};
    tabla[6]  = '{8'h5A, 3'd0, 2'b10, 8'h5A, 1'b0, 1'b0, 1'b0};
    tabla[7]  = '{8'h5A, 3'd0, 2'b11, 8'h5A, 1'b0, 1'b0, 1'b1};
    tabla[8]  = '{8'h3C, 3'd2, 2'b11, 8'h3C, 1'b0, 1'b0, 1'b1};
    tabla[9]  = '{8'h7F, 3'd7, 2'b01, 8'h00, 1'b1, 1'b1, 1'b0};
    tabla[10] = '{8'h96, 3'd4, 2'b10, 8'h69, 1'b0, 1'b0, 1'b0};
    tabla[11] = '{8'hC3, 3'd5, 2'b01, 8'hFE, 1'b0, 1'b0, 1'b0};

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_salida_valida", 32'(salida_valida), 0);
    check("reset_resultado", 32'(resultado), 0);
    check("reset_bandera_cero", 32'(bandera_cero), 0);
    check("reset_bandera_acarreo", 32'(bandera_acarreo), 0);
    check("reset_error_modo", 32'(error_modo), 0);
    check("reset_contador_ops", 32'(contador_ops), 0);
    check("reset_entrada_lista", 32'(entrada_lista), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("lista_tras_reset", 32'(entrada_lista), 1);
    exp_cnt = 8'd0;

    // Table-driven vectors; the first also checks acceptance-to-valid latency
    for (int i = 0; i < 12; i++) begin
      enviar(tabla[i].valor, tabla[i].cant, tabla[i].modo,
             {tabla[i].res, tabla[i].cero, tabla[i].acarreo, tabla[i].error}, (i == 0));
      recoger(0);
    end

    // Random vectors against the model, with random consumer stalls
    for (int i = 0; i < 30; i++) begin
      v = 8'($urandom_range(0, 255));
      c = 3'($urandom_range(0, 7));
      m = 2'($urandom_range(0, 3));
      enviar(v, c, m, modelo(v, c, m), 1'b0);
      recoger($urandom_range(0, 2));
    end

    // Consumer stall of 5 cycles while inputs keep changing
    enviar(8'hB4, 3'd3, 2'b00, {8'h16, 1'b0, 1'b1, 1'b0}, 1'b0);
    recoger(5);

    // Reset while the result is being presented
    enviar(8'h81, 3'd1, 2'b10, {8'hC0, 1'b0, 1'b1, 1'b0}, 1'b0);
    espera = 0;
    while (salida_valida !== 1'b1 && espera < 20) begin
      @(posedge clk); #1;
      espera++;
    end
    check("entrega_antes_reset", 32'(salida_valida), 1);
    rst_n = 1'b0;
    salida_lista = 1'b1;
    @(posedge clk); #1;
    salida_lista = 1'b0;
    check("reset_entrega_valida", 32'(salida_valida), 0);
    check("reset_entrega_resultado", 32'(resultado), 0);
    check("reset_entrega_acarreo", 32'(bandera_acarreo), 0);
    check("reset_entrega_contador", 32'(contador_ops), 0);
    check("reset_entrega_lista", 32'(entrada_lista), 0);
    exp_q.delete();
    exp_cnt = 8'd0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("lista_tras_reset_entrega", 32'(entrada_lista), 1);

    // Reset right after acceptance (unit in CALCULO): result must never appear
    enviar(8'hFF, 3'd2, 2'b00, {8'h3F, 1'b0, 1'b1, 1'b0}, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("sin_resultado_tras_reset_calculo", 32'(salida_valida), 0);
      check("contador_tras_reset_calculo", 32'(contador_ops), 0);
    end

    // 256 handshakes from zero: the counter wraps back to 0x00
    for (int i = 0; i < 256; i++) begin
      v = 8'($urandom_range(0, 255));
      c = 3'($urandom_range(0, 7));
      m = 2'($urandom_range(0, 3));
      enviar(v, c, m, modelo(v, c, m), 1'b0);
      recoger(0);
    end
    check("contador_vuelta_a_cero", 32'(contador_ops), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached (%0d/%0d checks passed)", pass_cnt, total_cnt);
    $fatal(1);
  end

endmodule
